// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encodings,
// PC increment and the NOP word consumers use for pipeline bubbles.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IFU_IDLE    = 2'd0,
    IFU_WAIT    = 2'd1,
    IFU_DISCARD = 2'd2
  } ifu_state_e;

  localparam int          PC_STEP   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/instruction_fetch_unit_fetch_fifo.sv
// Synchronous instruction buffer with push/pop/flush; flush overrides both.
// The head entry is presented combinationally and reads as zero when empty.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   valid_o,
  output logic [WIDTH-1:0]       head_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + PTR_W'(1);
      if (pop_i)  rd_q <= rd_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign count_o = cnt_q;
  assign valid_o = (cnt_q != '0);
  assign head_o  = valid_o ? mem_q[rd_q] : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues single outstanding PMEM requests,
// buffers returned words with their PC and honours redirects by flushing.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  output logic                pmem_req_o,
  output logic [PC_WIDTH-1:0] pmem_addr_o,
  input  logic                pmem_ack_i,
  input  logic [31:0]         pmem_rdata_i,
  input  logic                redirect_en_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
  output logic [31:0]         instr_o,
  output logic [PC_WIDTH-1:0] instr_pc_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] pmem_addr_q, pmem_addr_d;
  logic                pmem_req_q, pmem_req_d;
  logic [PC_WIDTH-1:0] next_pc;
  logic [CNT_W-1:0]    count;
  logic [CNT_W:0]      occ_after;
  logic [32+PC_WIDTH-1:0] head;
  logic                push, pop, idle_room, chain_room;

  assign pop     = instr_valid_o && instr_ready_i;
  assign push    = (state_q == IFU_WAIT) && pmem_ack_i && !redirect_en_i;
  assign next_pc = fetch_pc_q + PC_WIDTH'(PC_STEP);

  // Chaining a request on an ack must leave room for both the word being
  // pushed now and the one that will return later.
  assign occ_after  = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
  assign chain_room = occ_after < (CNT_W+1)'(FIFO_DEPTH);
  assign idle_room  = count < CNT_W'(FIFO_DEPTH);

  fetch_fifo #(
    .WIDTH (32 + PC_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  ({fetch_pc_q, pmem_rdata_i}),
    .pop_i   (pop),
    .flush_i (redirect_en_i),
    .count_o (count),
    .valid_o (instr_valid_o),
    .head_o  (head)
  );

  assign instr_pc_o  = head[32+PC_WIDTH-1:32];
  assign instr_o     = head[31:0];
  assign pmem_req_o  = pmem_req_q;
  assign pmem_addr_o = pmem_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IFU_IDLE;
      fetch_pc_q  <= RESET_PC;
      pmem_addr_q <= RESET_PC;
      pmem_req_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      pmem_addr_q <= pmem_addr_d;
      pmem_req_q  <= pmem_req_d;
    end
  end

  // WAIT issues the next request directly on an ack so a 1-cycle memory
  // sustains one instruction every two cycles.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pmem_addr_d = pmem_addr_q;
    pmem_req_d  = 1'b0;
    if (redirect_en_i) begin
      fetch_pc_d = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
      case (state_q)
        IFU_WAIT:    state_d = pmem_ack_i ? IFU_IDLE : IFU_DISCARD;
        IFU_DISCARD: if (pmem_ack_i) state_d = IFU_IDLE;
        default:     state_d = state_q;
      endcase
    end else begin
      case (state_q)
        IFU_IDLE: begin
          if (idle_room) begin
            pmem_req_d  = 1'b1;
            pmem_addr_d = fetch_pc_q;
            state_d     = IFU_WAIT;
          end
        end
        IFU_WAIT: begin
          if (pmem_ack_i) begin
            fetch_pc_d = next_pc;
            if (chain_room) begin
              pmem_req_d  = 1'b1;
              pmem_addr_d = next_pc;
            end else begin
              state_d = IFU_IDLE;
            end
          end
        end
        IFU_DISCARD: if (pmem_ack_i) state_d = IFU_IDLE;
        default:     state_d = IFU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized self-checking bench: PMEM responder plus a sequence-level
// model of expected request addresses, delivered PCs and buffer occupancy.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int          W      = 32;
  localparam logic [31:0] RST_PC = 32'h100;
  localparam int          DEPTH  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          pmem_req_o;
  logic [W-1:0]  pmem_addr_o;
  logic          pmem_ack_i;
  logic [31:0]   pmem_rdata_i;
  logic          redirect_en_i;
  logic [W-1:0]  redirect_pc_i;
  logic          instr_valid_o;
  logic          instr_ready_i;
  logic [31:0]   instr_o;
  logic [W-1:0]  instr_pc_o;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .PC_WIDTH   (W),
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pmem_req_o    (pmem_req_o),
    .pmem_addr_o   (pmem_addr_o),
    .pmem_ack_i    (pmem_ack_i),
    .pmem_rdata_i  (pmem_rdata_i),
    .redirect_en_i (redirect_en_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o)
  );

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  logic [31:0] reqExpect, delivExpect, outAddr, redirTarget;
  int   buffered, lat;
  bit   outstanding, stale, prevRedir, reqSeen, sawZeroReq;
  int   readyPct = 100, latMin = 1, latMax = 1, redirPct = 0;
  bit   redirOneShot = 0, redirOnAck = 0, redirOnAckHit = 0;
  int   reqCycles[$];

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  // One clock cycle: sample at negedge, drive inputs, advance the model.
  task automatic applyStimulus();
    logic ackNow, redirNow, readyNow;
    logic [31:0] tgt;
    @(negedge clk);
    cycle++;
    reqSeen = 0;
    checkOutput("valid_vs_occupancy", instr_valid_o, (buffered != 0));
    if (prevRedir) checkOutput("no_req_after_redirect", pmem_req_o, 0);
    if (outstanding && !pmem_req_o) checkOutput("addr_hold", pmem_addr_o, outAddr);

    ackNow = 0;
    if (outstanding) begin
      if (lat == 0) ackNow = 1;
      else lat--;
    end
    readyNow = ($urandom_range(99) < readyPct);
    redirNow = 0;
    tgt      = $urandom;
    if (redirPct > 0 && $urandom_range(99) < redirPct) redirNow = 1;
    if (redirOneShot) begin
      redirNow = 1; tgt = redirTarget; redirOneShot = 0;
    end
    if (redirOnAck && ackNow && instr_valid_o) begin
      redirNow = 1; readyNow = 1; tgt = redirTarget;
      redirOnAck = 0; redirOnAckHit = 1;
    end
    pmem_ack_i    = ackNow;
    pmem_rdata_i  = ackNow ? memWord(outAddr) : NOP_INSTR;
    instr_ready_i = readyNow;
    redirect_en_i = redirNow;
    redirect_pc_i = tgt;

    if (instr_valid_o && readyNow) begin
      checkOutput("instr_pc", instr_pc_o, delivExpect);
      checkOutput("instr_word", instr_o, memWord(delivExpect));
      delivExpect += 4;
      buffered--;
    end
    if (ackNow) begin
      outstanding = 0;
      if (!stale && !redirNow) buffered++;
      stale = 0;
      checkOutput("no_overflow", (buffered > DEPTH), 0);
    end
    if (pmem_req_o) begin
      checkOutput("single_outstanding", outstanding, 0);
      checkOutput("req_addr", pmem_addr_o, reqExpect);
      if (pmem_addr_o == 32'h0) sawZeroReq = 1;
      outAddr     = reqExpect;
      reqExpect  += 4;
      outstanding = 1;
      stale       = 0;
      lat         = $urandom_range(latMax, latMin) - 1;
      reqSeen     = 1;
      reqCycles.push_back(cycle);
    end
    if (redirNow) begin
      stale       = outstanding;
      buffered    = 0;
      reqExpect   = {tgt[31:2], 2'b00};
      delivExpect = {tgt[31:2], 2'b00};
    end
    prevRedir = redirNow;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic waitForReq(input int maxCycles);
    int n = 0;
    do begin
      applyStimulus();
      n++;
    end while (!reqSeen && n < maxCycles);
    checkOutput("wait_req_timeout", reqSeen, 1);
  endtask

  task automatic applyReset(input bit ackDuring);
    rst           = 1'b1;
    pmem_ack_i    = 1'b0;
    pmem_rdata_i  = NOP_INSTR;
    instr_ready_i = 1'b0;
    redirect_en_i = 1'b0;
    redirect_pc_i = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cycle++;
      checkOutput("rst_req", pmem_req_o, 0);
      checkOutput("rst_addr", pmem_addr_o, RST_PC);
      checkOutput("rst_valid", instr_valid_o, 0);
      checkOutput("rst_instr", instr_o, 0);
      checkOutput("rst_instr_pc", instr_pc_o, 0);
      pmem_ack_i   = ackDuring && (i == 0);
      pmem_rdata_i = pmem_ack_i ? 32'hDEAD_BEEF : NOP_INSTR;
    end
    @(negedge clk);
    pmem_ack_i  = 1'b0;
    rst         = 1'b0;
    reqExpect   = RST_PC;
    delivExpect = RST_PC;
    buffered    = 0;
    outstanding = 0;
    stale       = 0;
    prevRedir   = 0;
    lat         = 0;
    reqCycles.delete();
  endtask

  initial begin
    applyReset(0);

    // Streaming with a 1-cycle memory: one request every other cycle.
    readyPct = 100; latMin = 1; latMax = 1;
    runCycles(12);
    checkOutput("req_count", (reqCycles.size() >= 3), 1);
    if (reqCycles.size() >= 3) begin
      checkOutput("req_spacing_a", reqCycles[1] - reqCycles[0], 2);
      checkOutput("req_spacing_b", reqCycles[2] - reqCycles[1], 2);
    end

    // Consumer stall: buffer fills to depth and fetching stops.
    readyPct = 0;
    begin
      int lateReqs = 0;
      for (int i = 0; i < 10; i++) begin
        applyStimulus();
        if (i >= 4 && reqSeen) lateReqs++;
      end
      checkOutput("stall_no_req", lateReqs, 0);
      checkOutput("stall_buffered", buffered, DEPTH);
    end
    readyPct = 100;
    runCycles(10);

    // Redirect while a slow request is outstanding.
    latMin = 3; latMax = 3;
    waitForReq(20);
    redirTarget = 32'h203; redirOneShot = 1;
    runCycles(16);

    // Redirect coinciding with an ack and a pop.
    latMin = 1; latMax = 1; readyPct = 0;
    redirTarget = 32'h300; redirOnAck = 1; redirOnAckHit = 0;
    begin
      int n = 0;
      while (!redirOnAckHit && n < 40) begin
        applyStimulus();
        n++;
      end
    end
    checkOutput("redir_ack_pop_hit", redirOnAckHit, 1);
    redirOnAck = 0; readyPct = 100;
    runCycles(10);

    // PC wraps from the top of the address space.
    sawZeroReq = 0;
    redirTarget = 32'hFFFF_FFFC; redirOneShot = 1;
    runCycles(12);
    checkOutput("wrap_req_zero", sawZeroReq, 1);

    // Reset while a request is outstanding; its ack arrives during reset.
    latMin = 3; latMax = 3;
    waitForReq(20);
    applyReset(1);
    latMin = 1; latMax = 1;
    waitForReq(10);
    runCycles(8);

    // Random traffic.
    readyPct = 60; latMin = 1; latMax = 4; redirPct = 4;
    runCycles(600);
    redirPct = 0; readyPct = 100;
    runCycles(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
